uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Oversampling UART receive front-end that recovers 8N1 frames from the asynchronous `rx` pin and delivers bytes to the peripheral's receive FIFO logic. It synchronizes the pin, detects start bits, and majority-votes three mid-bit samples per bit. It emits a one-cycle `done` (good frame) or `err` (framing error) pulse with the byte. It sits directly upstream of the Rx FIFO write path and is driven by the baud generator's oversample strobe.

## Interface
- `Oversample`, default 16: ticks per bit; must be even and ≥ 8.
- `SyncStages`, default 2: flip-flops in the `in` synchronizer, ≥ 2.
- `clk`, input, 1: clock.
- `nReset`, input, 1: synchronous, active-low reset.
- `tick`, input, 1: one-cycle oversample strobe from the baud generator.
- `in`, input, 1: asynchronous serial line, idle high.
- `data`, output, 8: last received byte; valid while `done` or `err` is high; held otherwise.
- `done`, output, 1: one-cycle pulse; frame received with a valid stop bit.
- `err`, output, 1: one-cycle pulse; stop bit sampled low (framing error).
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- Reset values:
  - synchronizer chain all 1s; `data` = 0x00; `done` = `err` = `busy` = 0.
  - state IDLE; counters 0.
- All state and counter updates occur only on cycles with `tick` = 1. `done` and `err` self-clear on the next cycle regardless of `tick`.
- `s` denotes the synchronizer output. Sample points are ticks `M-1`, `M`, `M+1` of each bit, where `M` = `Oversample/2`. The bit value is the majority of the three samples.
- **IDLE:**
  - On a tick with `s` = 0, go to START with tick counter = 0.
  - Otherwise stay in IDLE.
- **START:**
  - Count ticks.
  - At tick `M+1`, evaluate the majority vote. Majority 1 is a false start: return to IDLE silently, with no `err`. Majority 0 continues.
  - At tick `Oversample-1`, go to DATA with bit counter = 0.
- **DATA:**
  - Each bit spans `Oversample` ticks.
  - At tick `M+1`, shift the majority value into the shift register, LSB first.
  - After bit 7 completes at tick `Oversample-1`, go to STOP.
- **STOP:**
  - At tick `M+1`, evaluate the majority vote.
  - Majority 1: load `data` from the shift register, pulse `done`, go to IDLE. Leaving at mid-stop permits back-to-back frames.
  - Majority 0: load `data`, pulse `err`, go to BREAK.
- **BREAK:**
  - Wait for a tick with `s` = 1, then go to IDLE. This prevents a low line or break condition from retriggering a frame.
- `done` and `err` are never high together.
- Width rules:
  - Tick counter is `$clog2(Oversample)` bits and wraps to 0 at `Oversample-1`.
  - Bit counter is 3 bits.
- Reset asserted mid-frame aborts the frame with no pulse; all state returns to reset values on the next edge.
- `in` toggling between ticks has no effect beyond the synchronizer.

## Timing
- Pin-to-`s` latency is `SyncStages` clk cycles.
- The start-detect tick is T0, with counter = 0.
- The stop decision occurs at tick T0 + 9·`Oversample` + `M` + 1, which is tick 153 for the defaults.
- `data`, `done` and `err` are registered and update on the clk edge following the stop-decision tick. `done`/`err` are high for exactly one cycle.
- `busy` rises in the cycle after T0. It falls together with `done` on a good frame, or on exit from BREAK.
- A new start bit may be detected on the first tick after returning to IDLE.

## Structure
- `uart_pkg` holds:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_BITS` = 8.
- One sub-module, `sync_chain` (parameter `SyncStages`, reset value 1), for the metastability synchronizer. It is reusable for `cts`.
- Majority vote is a 3-bit sample register plus combinational vote, kept inline.

## Test plan
- Tick every cycle, frame 0xA5 (bits LSB-first 1,0,1,0,0,1,0,1, stop 1), each bit held 16 cycles → `done` pulse exactly 1 cycle, `data` = 0xA5, `err` never high; latency 153 ticks + 1 cycle from start detect.
- Low glitch of 5 ticks on an idle line → START entered, majority 1 at tick 9 → IDLE, no `done`/`err`, `busy` drops.
- Frame 0x3C with stop bit held low, then line high → `err` pulse with `data` = 0x3C, state BREAK until `in` = 1, then a following frame 0x81 → `done` with 0x81.
- Single-tick spikes of opposite polarity at sample point M on every data bit of 0x55 → majority rejects them, `done` with `data` = 0x55.
- Two back-to-back frames 0x00 then 0xFF with one stop bit, `tick` asserted every 3rd cycle → two `done` pulses with `data` = 0x00 then 0xFF.
- `nReset` low for 1 cycle during bit 4 of a frame → no pulse; outputs = 0, `busy` = 0; a subsequent full frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Two-of-three vote used on the mid-bit samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receive-side handshake between the pin/baud strobe and the Rx FIFO write path.
interface uart_rx_sampler_if;
  import uart_pkg::*;

  logic                      tick;
  logic                      in;
  logic [UART_DATA_BITS-1:0] data;
  logic                      done;
  logic                      err;
  logic                      busy;

  modport master (output tick, in, input data, done, err, busy);
  modport slave  (input tick, in, output data, done, err, busy);

endinterface

// File: rtl/uart_rx_sampler_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input (rx, cts).
module sync_chain #(
  parameter int unsigned SyncStages = 2,
  parameter logic        RstVal     = 1'b1
) (
  input  logic clk,
  input  logic nReset,
  input  logic d_i,
  output logic q_o
);

  logic [SyncStages-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nReset) sync_q <= {SyncStages{RstVal}};
    else         sync_q <= {sync_q[SyncStages-2:0], d_i};
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 receiver: start detect, 3-sample mid-bit majority vote,
// one-cycle done/err pulse with the received byte.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned Oversample = 16,
  parameter int unsigned SyncStages = 2
) (
  input logic              clk,
  input logic              nReset,
  uart_rx_sampler_if.slave rx
);

  localparam int unsigned CntW = $clog2(Oversample);
  localparam int unsigned Mid  = Oversample / 2;
  localparam int unsigned BitW = 3;

  logic s;

  sync_chain #(.SyncStages(SyncStages), .RstVal(1'b1)) u_sync (
    .clk   (clk),
    .nReset(nReset),
    .d_i   (rx.in),
    .q_o   (s)
  );

  rx_state_t                 state_q;
  logic [CntW-1:0]           cnt_q;
  logic [BitW-1:0]           bit_q;
  logic [1:0]                samp_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      done_q;
  logic                      err_q;
  logic                      busy_q;

  // cnt_q holds the index of the last processed tick; idx_c is this tick's index.
  logic [CntW-1:0] idx_c;
  logic            sample_pt_c;
  logic            vote_pt_c;
  logic            last_c;
  logic            maj_c;

  assign idx_c       = (cnt_q == CntW'(Oversample - 1)) ? '0 : cnt_q + CntW'(1);
  assign sample_pt_c = (idx_c >= CntW'(Mid - 1)) && (idx_c <= CntW'(Mid + 1));
  assign vote_pt_c   = (idx_c == CntW'(Mid + 1));
  assign last_c      = (idx_c == CntW'(Oversample - 1));
  // Third sample is the live synchronizer output so the vote lands on tick M+1.
  assign maj_c       = maj3({samp_q, s});

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (rx.tick) begin
        if (state_q inside {START, DATA, STOP}) begin
          cnt_q <= idx_c;
          if (sample_pt_c) samp_q <= {samp_q[0], s};
        end
        case (state_q)
          IDLE: begin
            if (!s) begin
              state_q <= START;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (vote_pt_c && maj_c) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (last_c) begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
          DATA: begin
            if (vote_pt_c) shift_q <= {maj_c, shift_q[UART_DATA_BITS-1:1]};
            if (last_c) begin
              if (bit_q == BitW'(UART_DATA_BITS - 1)) state_q <= STOP;
              else                                     bit_q   <= bit_q + BitW'(1);
            end
          end
          STOP: begin
            if (vote_pt_c) begin
              data_q <= shift_q;
              if (maj_c) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                err_q   <= 1'b1;
                state_q <= BREAK;
              end
            end
          end
          BREAK: begin
            // Hold off until the line returns high so a break cannot retrigger.
            if (s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx.data = data_q;
  assign rx.done = done_q;
  assign rx.err  = err_q;
  assign rx.busy = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: vector table, corner sequences, random frames.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  localparam int unsigned OS   = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned M    = OS / 2;
  localparam longint      LAT  = SYNC + 1 + 9 * OS + M + 1;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler #(.Oversample(OS), .SyncStages(SYNC)) dut (
    .clk   (clk),
    .nReset(nReset),
    .rx    (rx_if)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  int     tick_div = 1;
  int     ph = 0;
  longint cyc_n = 0;
  longint start_cyc = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] d;
    longint     cyc;
  } ev_t;

  typedef struct {
    logic [7:0] byte_v;
    logic       stop;
    int         tdiv;
    logic       exp_err;
    logic [7:0] exp_data;
    logic       chk_lat;
  } vec_t;

  ev_t  got_q[$];
  vec_t vecs[6];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Record every pulse; pulses must be exclusive and busy must track them.
  always @(negedge clk) begin
    if (nReset === 1'b1 && (rx_if.done === 1'b1 || rx_if.err === 1'b1)) begin
      check("done_err_exclusive", longint'(rx_if.done & rx_if.err), 0);
      if (rx_if.done) check("busy_low_with_done", longint'(rx_if.busy), 0);
      else            check("busy_high_with_err", longint'(rx_if.busy), 1);
      got_q.push_back('{rx_if.err, rx_if.data, cyc_n});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % tick_div;
    rx_if.tick = (ph == 0);
  endtask

  task automatic drive(input logic v, input int n);
    int k = 0;
    rx_if.in = v;
    while (k < n) begin
      if (rx_if.tick) k++;
      step();
    end
  endtask

  task automatic send_bit(input logic v, input int gpos);
    if (gpos < 0) drive(v, OS);
    else begin
      drive(v, gpos);
      drive(!v, 1);
      drive(v, OS - gpos - 1);
    end
  endtask

  // gmode: 0 clean, 1 spike at M on each data bit, 2 random spike or none per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_ticks,
                            input int gap, input int gmode);
    int gp;
    start_cyc = cyc_n;
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      if (gmode == 0) gp = -1;
      else if (gmode == 1) gp = M;
      else gp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, OS - 2)) : -1;
      send_bit(b[i], gp);
    end
    drive(stop, stop_ticks);
    drive(1'b1, gap);
  endtask

  task automatic expect_ev(input string name, input logic exp_err, input logic [7:0] exp_data,
                           input logic chk_lat);
    ev_t ev;
    check({name, "_present"}, longint'(got_q.size() > 0), 1);
    if (got_q.size() > 0) begin
      ev = got_q.pop_front();
      check({name, "_kind"}, longint'(ev.is_err), longint'(exp_err));
      check({name, "_data"}, longint'(ev.d), longint'(exp_data));
      if (chk_lat) check({name, "_latency"}, ev.cyc - start_cyc, LAT);
    end
  endtask

  task automatic expect_none(input string name);
    check({name, "_no_extra_pulse"}, longint'(got_q.size()), 0);
    got_q.delete();
  endtask

  // Reference: a frame yields its byte; the stop-bit level alone decides done vs err.
  function automatic ev_t model_frame(input logic [7:0] b, input logic stop);
    return '{!stop, b, 0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t        mexp;
    logic [7:0] rb;
    logic       rstop;
    int         rgap;

    vecs[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1, 1'b0, 8'h81, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 2, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 3, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 2, 1'b1, 8'h5A, 1'b0};

    rx_if.tick = 1'b1;
    rx_if.in   = 1'b1;
    nReset     = 1'b0;
    repeat (4) step();
    check("reset_data", longint'(rx_if.data), 0);
    check("reset_done", longint'(rx_if.done), 0);
    check("reset_err",  longint'(rx_if.err), 0);
    check("reset_busy", longint'(rx_if.busy), 0);
    nReset = 1'b1;
    drive(1'b1, 4);

    // Vector table.
    foreach (vecs[i]) begin
      tick_div = vecs[i].tdiv;
      send_frame(vecs[i].byte_v, vecs[i].stop, OS, 4, 0);
      expect_ev($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_data, vecs[i].chk_lat);
      check($sformatf("vec%0d_data_held", i), longint'(rx_if.data), longint'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy_idle", i), longint'(rx_if.busy), 0);
      expect_none($sformatf("vec%0d", i));
    end

    // False start: 5-tick low glitch.
    tick_div = 1;
    drive(1'b1, 4);
    drive(1'b0, 5);
    check("glitch_busy_rise", longint'(rx_if.busy), 1);
    drive(1'b1, 12);
    check("glitch_busy_fall", longint'(rx_if.busy), 0);
    expect_none("glitch");

    // Framing error with extended break, then a good frame.
    send_frame(8'h3C, 1'b0, OS + 20, 0, 0);
    expect_ev("break_err", 1'b1, 8'h3C, 1'b0);
    check("break_busy_held", longint'(rx_if.busy), 1);
    drive(1'b1, 4);
    check("break_exit_busy", longint'(rx_if.busy), 0);
    send_frame(8'h81, 1'b1, OS, 4, 0);
    expect_ev("after_break", 1'b0, 8'h81, 1'b0);
    expect_none("break");

    // Spikes at the centre sample of every data bit.
    send_frame(8'h55, 1'b1, OS, 4, 1);
    expect_ev("spike55", 1'b0, 8'h55, 1'b0);
    expect_none("spike55");

    // Back-to-back frames, tick every 3rd cycle.
    tick_div = 3;
    send_frame(8'h00, 1'b1, OS, 0, 0);
    send_frame(8'hFF, 1'b1, OS, 4, 0);
    expect_ev("b2b_first", 1'b0, 8'h00, 1'b0);
    expect_ev("b2b_second", 1'b0, 8'hFF, 1'b0);
    expect_none("b2b");

    // Reset during bit 4 aborts silently.
    tick_div = 1;
    drive(1'b0, OS);
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b0, OS);
    drive(1'b0, OS);
    drive(1'b1, 5);
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    check("midrst_data", longint'(rx_if.data), 0);
    check("midrst_done", longint'(rx_if.done), 0);
    check("midrst_err",  longint'(rx_if.err), 0);
    check("midrst_busy", longint'(rx_if.busy), 0);
    drive(1'b1, 20);
    expect_none("midrst_abort");
    send_frame(8'h12, 1'b1, OS, 4, 0);
    expect_ev("midrst_next", 1'b0, 8'h12, 1'b0);
    expect_none("midrst");

    // Random frames with random spikes and tick rates.
    for (int it = 0; it < 40; it++) begin
      tick_div = int'($urandom_range(1, 3));
      rb       = 8'($urandom);
      rstop    = ($urandom_range(0, 3) != 0);
      rgap     = rstop ? int'($urandom_range(0, 5)) : int'($urandom_range(2, 6));
      send_frame(rb, rstop, OS, rgap, 2);
      mexp = model_frame(rb, rstop);
      expect_ev($sformatf("rand%0d", it), mexp.is_err, mexp.d, 1'b0);
    end
    drive(1'b1, 4);
    expect_none("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
